// File: rtl/countdown_timer.sv
// Loadable down-counter / interval timer with prescaler, pause, and optional auto-reload.
// Optional wrap counter output `wraps` is built when COUNTDOWN_WRAP_CNT_EN is defined.
module countdown_timer #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
`ifdef COUNTDOWN_WRAP_CNT_EN
   ,
   output logic [7:0]       wraps
`endif
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]       state, state_nx;
   logic [WIDTH-1:0] count_nx;
   logic [WIDTH-1:0] reload, reload_nx;
   logic [PW-1:0]    pre, pre_nx;
   logic             done_nx;
   logic             active;
   logic             tick;
`ifdef COUNTDOWN_WRAP_CNT_EN
   logic [7:0]       wraps_nx;
`endif

   assign active = (state == S_RUN) || (state == S_HOLD);
   // HOLD with pause released behaves as RUN on that edge, so a pause of N cycles delays by exactly N.
   assign tick   = active && !pause && (pre == PRE_LAST);
   assign busy   = active;

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_nx  = state;
      count_nx  = count;
      reload_nx = reload;
      pre_nx    = pre;
      done_nx   = 1'b0;
`ifdef COUNTDOWN_WRAP_CNT_EN
      wraps_nx  = wraps;
`endif
      if (load) begin
         count_nx  = load_val;
         reload_nx = load_val;
         pre_nx    = '0;
         state_nx  = S_IDLE;
`ifdef COUNTDOWN_WRAP_CNT_EN
         wraps_nx  = '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (count != '0) begin
                     state_nx = S_RUN;
                     pre_nx   = '0;
                  end else begin
                     done_nx  = 1'b1;
                  end
               end
            end
            S_RUN, S_HOLD: begin
               if (pause) begin
                  state_nx = S_HOLD;
               end else begin
                  state_nx = S_RUN;
                  if (tick) begin
                     pre_nx = '0;
                     if (count > WIDTH'(1)) begin
                        count_nx = count - WIDTH'(1);
                     end else if (count == WIDTH'(1)) begin
                        done_nx = 1'b1;
                        if (auto_reload && (reload != '0)) begin
                           count_nx = reload;
`ifdef COUNTDOWN_WRAP_CNT_EN
                           if (wraps != 8'hFF) wraps_nx = wraps + 8'd1;
`endif
                        end else begin
                           count_nx = '0;
                           state_nx = S_IDLE;
                        end
                     end else begin
                        // Zero count while running cannot arise normally; never wrap below zero.
                        state_nx = S_IDLE;
                     end
                  end else begin
                     pre_nx = pre + PW'(1);
                  end
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= S_IDLE;
         count  <= '0;
         reload <= '0;
         pre    <= '0;
         done   <= 1'b0;
`ifdef COUNTDOWN_WRAP_CNT_EN
         wraps  <= '0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state  <= state_nx;
         count  <= count_nx;
         reload <= reload_nx;
         pre    <= pre_nx;
         done   <= done_nx;
`ifdef COUNTDOWN_WRAP_CNT_EN
         wraps  <= wraps_nx;
`endif
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one instance with PRESCALE=1, one with PRESCALE=4, shared inputs.
module tb_countdown_timer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         start = 1'b0;
   logic         pause = 1'b0;
   logic         auto_reload = 1'b0;

   logic [W-1:0] count1, count4;
   logic         busy1, busy4, done1, done4;
`ifdef COUNTDOWN_WRAP_CNT_EN
   logic [7:0]   wraps1, wraps4;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   countdown_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (
      .clk(clk), .rstn(rstn), .load(load), .load_val(load_val), .start(start),
      .pause(pause), .auto_reload(auto_reload), .count(count1), .busy(busy1), .done(done1)
`ifdef COUNTDOWN_WRAP_CNT_EN
      , .wraps(wraps1)
`endif
   );

   countdown_timer #(.WIDTH(W), .PRESCALE(4)) dut4 (
      .clk(clk), .rstn(rstn), .load(load), .load_val(load_val), .start(start),
      .pause(pause), .auto_reload(auto_reload), .count(count4), .busy(busy4), .done(done4)
`ifdef COUNTDOWN_WRAP_CNT_EN
      , .wraps(wraps4)
`endif
   );

   // Advance n rising edges; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [W-1:0] v);
      load = 1'b1; load_val = v;
      step(1);
      load = 1'b0;
   endtask

   task automatic test_reset;
      n_tests++;
      if (count1 !== 8'd0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_init: count=%0d busy=%b done=%b, need 0/0/0", count1, busy1, done1);
      end
      rstn = 1'b1;
      step(1);
      do_load(8'd8);
      start = 1'b1; step(1); start = 1'b0;
      step(3);
      n_tests++;
      if (count1 !== 8'd5 || busy1 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_pre: count=%0d busy=%b, need 5/1", count1, busy1);
      end
      #2 rstn = 1'b0;
      #1;
      n_tests++;
      if (count1 !== 8'd0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: count=%0d busy=%b done=%b, need 0/0/0", count1, busy1, done1);
      end
      #19 rstn = 1'b1;
      step(1);
      n_tests++;
      if (count1 !== 8'd0 || busy1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_after: count=%0d busy=%b, need 0/0", count1, busy1);
      end
   endtask

   task automatic test_oneshot;
      logic [W-1:0] exp_cnt [4];
      logic         exp_done [4];
      logic         exp_busy [4];
      exp_cnt  = '{8'd3, 8'd2, 8'd1, 8'd0};
      exp_done = '{1'b0, 1'b0, 1'b0, 1'b1};
      exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0};
      do_load(8'd3);
      start = 1'b1; step(1); start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (count1 !== exp_cnt[k] || done1 !== exp_done[k] || busy1 !== exp_busy[k]) begin
            n_fail++;
            $display("FAIL oneshot_N+%0d: count=%0d done=%b busy=%b, need %0d/%b/%b",
                     k, count1, done1, busy1, exp_cnt[k], exp_done[k], exp_busy[k]);
         end
         if (k < 3) step(1);
      end
      step(1);
      n_tests++;
      if (done1 !== 1'b0 || count1 !== 8'd0) begin
         n_fail++;
         $display("FAIL oneshot_after: done=%b count=%0d, need 0/0", done1, count1);
      end
   endtask

   task automatic test_auto_reload;
      logic [W-1:0] ec;
      logic         ed;
      do_load(8'd2);
      auto_reload = 1'b1;
      start = 1'b1; step(1); start = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         step(1);
         ec = ((k % 8) >= 4) ? 8'd1 : 8'd2;
         ed = ((k % 8) == 0);
         n_tests++;
         if (count4 !== ec || done4 !== ed || busy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_reload_N+%0d: count=%0d done=%b busy=%b, need %0d/%b/1",
                     k, count4, done4, busy4, ec, ed);
         end
`ifdef COUNTDOWN_WRAP_CNT_EN
         n_tests++;
         if (wraps4 !== 8'(k / 8)) begin
            n_fail++;
            $display("FAIL wraps_N+%0d: wraps=%0d, need %0d", k, wraps4, k / 8);
         end
`endif
      end
      auto_reload = 1'b0;
      do_load(8'd0);
      n_tests++;
      if (busy4 !== 1'b0 || count4 !== 8'd0) begin
         n_fail++;
         $display("FAIL auto_reload_stop: busy=%b count=%0d, need 0/0", busy4, count4);
      end
`ifdef COUNTDOWN_WRAP_CNT_EN
      n_tests++;
      if (wraps4 !== 8'd0) begin
         n_fail++;
         $display("FAIL wraps_clear: wraps=%0d, need 0", wraps4);
      end
`endif
   endtask

   task automatic test_pause;
      do_load(8'd5);
      start = 1'b1; step(1); start = 1'b0;
      step(2);
      n_tests++;
      if (count1 !== 8'd3) begin
         n_fail++;
         $display("FAIL pause_pre: count=%0d, need 3", count1);
      end
      pause = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step(1);
         n_tests++;
         if (count1 !== 8'd3 || busy1 !== 1'b1 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_hold_%0d: count=%0d busy=%b done=%b, need 3/1/0",
                     k, count1, busy1, done1);
         end
      end
      pause = 1'b0;
      step(2);
      n_tests++;
      if (count1 !== 8'd1 || done1 !== 1'b0) begin
         n_fail++;
         $display("FAIL pause_resume: count=%0d done=%b, need 1/0", count1, done1);
      end
      step(1);
      n_tests++;
      if (count1 !== 8'd0 || done1 !== 1'b1 || busy1 !== 1'b0) begin
         n_fail++;
         $display("FAIL pause_done: count=%0d done=%b busy=%b, need 0/1/0", count1, done1, busy1);
      end
   endtask

   task automatic test_abort;
      do_load(8'd8);
      start = 1'b1; step(1); start = 1'b0;
      step(4);
      n_tests++;
      if (count1 !== 8'd4 || busy1 !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_pre: count=%0d busy=%b, need 4/1", count1, busy1);
      end
      load = 1'b1; load_val = 8'd7; start = 1'b1;
      step(1);
      load = 1'b0; start = 1'b0;
      n_tests++;
      if (count1 !== 8'd7 || busy1 !== 1'b0 || done1 !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_load: count=%0d busy=%b done=%b, need 7/0/0", count1, busy1, done1);
      end
      for (int k = 0; k < 4; k++) begin
         step(1);
         n_tests++;
         if (count1 !== 8'd7 || done1 !== 1'b0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle_%0d: count=%0d done=%b busy=%b, need 7/0/0",
                     k, count1, done1, busy1);
         end
      end
   endtask

   task automatic test_zero_start;
      do_load(8'd0);
      start = 1'b1; step(1); start = 1'b0;
      n_tests++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || count1 !== 8'd0) begin
         n_fail++;
         $display("FAIL zero_start: done=%b busy=%b count=%0d, need 1/0/0", done1, busy1, count1);
      end
      step(1);
      n_tests++;
      if (done1 !== 1'b0 || busy1 !== 1'b0 || count1 !== 8'd0) begin
         n_fail++;
         $display("FAIL zero_after: done=%b busy=%b count=%0d, need 0/0/0", done1, busy1, count1);
      end
   endtask

   initial begin
      #3;
      test_reset;
      test_oneshot;
      test_auto_reload;
      test_pause;
      test_abort;
      test_zero_start;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
